// File: rtl/power_domain_sequencer.sv
// rtl/power_domain_sequencer.sv - per-domain power/isolation/retention sequencer
module power_domain_sequencer #(
   parameter int NUM_DOMAINS = 8,
   parameter int ISO_CYCLES  = 4,
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NUM_DOMAINS-1:0] domain_req_i,
   input  logic [NUM_DOMAINS-1:0] ret_req_i,
   input  logic [NUM_DOMAINS-1:0] pwr_ack_i,
   input  logic                   err_clear_i,
   output logic [NUM_DOMAINS-1:0] pwr_en_o,
   output logic [NUM_DOMAINS-1:0] iso_o,
   output logic [NUM_DOMAINS-1:0] save_o,
   output logic [NUM_DOMAINS-1:0] restore_o,
   output logic [NUM_DOMAINS-1:0] ret_o,
   output logic [NUM_DOMAINS-1:0] domain_on_o,
   output logic                   busy_o,
   output logic [NUM_DOMAINS-1:0] timeout_err_o,
   output logic [31:0]            transition_count_o
);

   localparam int TMAX = (ISO_CYCLES > ACK_TIMEOUT) ? ISO_CYCLES : ACK_TIMEOUT;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] ISO_LAST = TW'(ISO_CYCLES - 1);
   localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_ON, S_ISO, S_SAVE, S_PD_WAIT, S_OFF, S_PU_WAIT, S_RESTORE, S_DEISO, S_ERR
   } state_e;

   logic [NUM_DOMAINS-1:0] done;     // completed ON->OFF or OFF->ON this cycle
   logic [NUM_DOMAINS-1:0] busy_vec;

   for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
      state_e        state_q;
      logic [TW-1:0] timer_q;
      logic          ret_sel_q;      // retention choice latched when leaving ON
      logic          pwr_en_q;
      logic          iso_q;
      logic          save_q;
      logic          restore_q;
      logic          ret_q;
      logic          on_q;
      logic          terr_q;

      // Completion decode mirrors the FSM exits into OFF and ON
      assign done[i] = ((state_q == S_PD_WAIT) && !pwr_ack_i[i]) ||
                       ((state_q == S_DEISO) && (timer_q == ISO_LAST));
      assign busy_vec[i] = (state_q != S_ON) && (state_q != S_OFF);

      assign pwr_en_o[i]      = pwr_en_q;
      assign iso_o[i]         = iso_q;
      assign save_o[i]        = save_q;
      assign restore_o[i]     = restore_q;
      assign ret_o[i]         = ret_q;
      assign domain_on_o[i]   = on_q;
      assign timeout_err_o[i] = terr_q;

      // Domain FSM; outputs are registered alongside the state they belong to
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            state_q   <= S_ON;
            timer_q   <= '0;
            ret_sel_q <= 1'b0;
            pwr_en_q  <= 1'b1;
            iso_q     <= 1'b0;
            save_q    <= 1'b0;
            restore_q <= 1'b0;
            ret_q     <= 1'b0;
            on_q      <= 1'b1;
            terr_q    <= 1'b0;
         end else begin
            save_q    <= 1'b0;
            restore_q <= 1'b0;
            if (err_clear_i) terr_q <= 1'b0;
            case (state_q)
               S_ON: begin
                  if (!domain_req_i[i]) begin
                     state_q   <= S_ISO;
                     timer_q   <= '0;
                     ret_sel_q <= ret_req_i[i];
                     iso_q     <= 1'b1;
                     on_q      <= 1'b0;
                  end
               end
               S_ISO: begin
                  if (timer_q == ISO_LAST) begin
                     timer_q <= '0;
                     if (ret_sel_q) begin
                        state_q <= S_SAVE;
                        save_q  <= 1'b1;
                     end else begin
                        state_q  <= S_PD_WAIT;
                        pwr_en_q <= 1'b0;
                     end
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
               S_SAVE: begin
                  state_q  <= S_PD_WAIT;
                  timer_q  <= '0;
                  pwr_en_q <= 1'b0;
                  ret_q    <= 1'b1;
               end
               S_PD_WAIT: begin
                  if (!pwr_ack_i[i]) begin
                     state_q <= S_OFF;
                     timer_q <= '0;
                  end else if (timer_q == ACK_LAST) begin
                     state_q <= S_ERR;
                     timer_q <= '0;
                     terr_q  <= 1'b1;
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
               S_OFF: begin
                  if (domain_req_i[i]) begin
                     state_q  <= S_PU_WAIT;
                     timer_q  <= '0;
                     pwr_en_q <= 1'b1;
                  end
               end
               S_PU_WAIT: begin
                  if (pwr_ack_i[i]) begin
                     timer_q <= '0;
                     if (ret_q) begin
                        state_q   <= S_RESTORE;
                        restore_q <= 1'b1;
                     end else begin
                        state_q <= S_DEISO;
                     end
                  end else if (timer_q == ACK_LAST) begin
                     state_q  <= S_ERR;
                     timer_q  <= '0;
                     pwr_en_q <= 1'b0;
                     terr_q   <= 1'b1;
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
               S_RESTORE: begin
                  state_q <= S_DEISO;
                  timer_q <= '0;
                  ret_q   <= 1'b0;
               end
               S_DEISO: begin
                  if (timer_q == ISO_LAST) begin
                     state_q <= S_ON;
                     timer_q <= '0;
                     iso_q   <= 1'b0;
                     on_q    <= 1'b1;
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
               S_ERR: begin
                  if (err_clear_i) begin
                     state_q <= S_OFF;
                     timer_q <= '0;
                  end
               end
               default: begin
                  state_q  <= S_ERR;
                  timer_q  <= '0;
                  pwr_en_q <= 1'b0;
                  iso_q    <= 1'b1;
                  on_q     <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy_o = |busy_vec;

   logic [5:0]  add_d;
   logic [32:0] sum_d;
   logic [31:0] count_d;
   logic [31:0] count_q;

   // Popcount of same-cycle completions, added with saturation
   always_comb begin
      add_d = '0;
      for (int k = 0; k < NUM_DOMAINS; k++) add_d = add_d + 6'(done[k]);
      sum_d   = {1'b0, count_q} + 33'(add_d);
      count_d = sum_d[32] ? 32'hFFFF_FFFF : sum_d[31:0];
   end

   // Transition counter register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) count_q <= '0;
      else         count_q <= count_d;
   end

   assign transition_count_o = count_q;

endmodule

// File: tb/tb_power_domain_sequencer.sv
// tb/tb_power_domain_sequencer.sv - scoreboard bench for power_domain_sequencer
module tb_power_domain_sequencer;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [7:0] domain_req_i, ret_req_i, pwr_ack_i;
   logic       err_clear_i;
   logic [7:0] pwr_en_o, iso_o, save_o, restore_o, ret_o, domain_on_o, timeout_err_o;
   logic       busy_o;
   logic [31:0] transition_count_o;

   power_domain_sequencer #(.NUM_DOMAINS(8), .ISO_CYCLES(4), .ACK_TIMEOUT(1023)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .domain_req_i(domain_req_i), .ret_req_i(ret_req_i),
      .pwr_ack_i(pwr_ack_i), .err_clear_i(err_clear_i), .pwr_en_o(pwr_en_o), .iso_o(iso_o),
      .save_o(save_o), .restore_o(restore_o), .ret_o(ret_o), .domain_on_o(domain_on_o),
      .busy_o(busy_o), .timeout_err_o(timeout_err_o), .transition_count_o(transition_count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [7:0]  save, restore, ret, iso, pwr, don, terr;
      logic [31:0] cnt;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic [31:0] prev_cnt = '0;
   logic [7:0]  prev_terr = '0;

   function automatic obs_t cur_obs();
      return '{save_o, restore_o, ret_o, iso_o, pwr_en_o, domain_on_o, timeout_err_o, transition_count_o};
   endfunction

   task automatic push(input logic [7:0] s, r, rt, i, p, d, t, input logic [31:0] c);
      obs_t e;
      e = '{s, r, rt, i, p, d, t, c};
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, want);
      end
   endtask

   // Monitor: every pulse, counter change or error-flag change is an output event
   always begin
      obs_t cur, e;
      @(negedge clk_i);
      cur = cur_obs();
      if (cur.save != 0 || cur.restore != 0 || cur.cnt != prev_cnt || cur.terr != prev_terr) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got %h", cur);
         end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
               errors++;
               $display("FAIL event got %h expected %h", cur, e);
            end
         end
      end
      prev_cnt  = cur.cnt;
      prev_terr = cur.terr;
   end

   // sel: 0 pwr_en, 1 iso, 2 save, 3 restore
   task automatic wait_bit(input int sel, input int idx, input logic val, input string name);
      logic b;
      for (int n = 0; n < 2000; n++) begin
         case (sel)
            0: b = pwr_en_o[idx];
            1: b = iso_o[idx];
            2: b = save_o[idx];
            default: b = restore_o[idx];
         endcase
         if (b === val) return;
         @(negedge clk_i);
      end
      checks++; errors++;
      $display("FAIL timeout_%s got %b expected %b", name, b, val);
   endtask

   task automatic wait_cnt(input logic [31:0] v);
      for (int n = 0; n < 2000; n++) begin
         if (transition_count_o === v) return;
         @(negedge clk_i);
      end
      checks++; errors++;
      $display("FAIL timeout_count got %h expected %h", transition_count_o, v);
   endtask

   task automatic check_reset(input string name);
      obs_t r;
      r = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 32'h0};
      check({name, "_outs"}, 32'(cur_obs() != r), 32'd0);
      check({name, "_cnt"}, transition_count_o, 32'h0);
      check({name, "_pwr"}, 32'(pwr_en_o), 32'hFF);
      check({name, "_busy"}, 32'(busy_o), 32'd0);
   endtask

   initial begin
      int n;
      rst_ni = 1'b1; domain_req_i = 8'hFF; ret_req_i = 8'h00; pwr_ack_i = 8'hFF; err_clear_i = 1'b0;
      #2 rst_ni = 1'b0;
      #1 check_reset("reset");
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Domain 2 retained power-down
      push(8'h04, 8'h00, 8'h00, 8'h04, 8'hFF, 8'hFB, 8'h00, 32'd0);
      push(8'h00, 8'h00, 8'h04, 8'h04, 8'hFB, 8'hFB, 8'h00, 32'd1);
      domain_req_i[2] = 1'b0; ret_req_i[2] = 1'b1;
      n = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk_i);
         if (save_o[2]) break;
         if (iso_o[2]) n++;
      end
      check("iso_before_save", n, 4);
      check("busy_in_seq", 32'(busy_o), 32'd1);
      wait_bit(0, 2, 1'b0, "pd2_pwr_off");
      repeat (3) @(negedge clk_i);
      pwr_ack_i[2] = 1'b0;
      wait_cnt(32'd1);
      check("ret2_after_off", 32'(ret_o[2]), 32'd1);
      check("busy_idle", 32'(busy_o), 32'd0);

      // Domain 2 restore power-up
      push(8'h00, 8'h04, 8'h04, 8'h04, 8'hFF, 8'hFB, 8'h00, 32'd1);
      push(8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 32'd2);
      domain_req_i[2] = 1'b1;
      wait_bit(0, 2, 1'b1, "pu2_pwr_on");
      repeat (5) @(negedge clk_i);
      pwr_ack_i[2] = 1'b1;
      wait_bit(3, 2, 1'b1, "restore2");
      n = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk_i);
         if (!iso_o[2]) break;
         n++;
      end
      check("deiso_cycles", n, 4);
      check("ret2_after_restore", 32'(ret_o[2]), 32'd0);
      check("on2", 32'(domain_on_o[2]), 32'd1);

      // Domain 0 power-down, then power-up timeout
      push(8'h00, 8'h00, 8'h00, 8'h01, 8'hFE, 8'hFE, 8'h00, 32'd3);
      domain_req_i[0] = 1'b0; ret_req_i[0] = 1'b0;
      wait_bit(0, 0, 1'b0, "pd0_pwr_off");
      pwr_ack_i[0] = 1'b0;
      wait_cnt(32'd3);
      push(8'h00, 8'h00, 8'h00, 8'h01, 8'hFE, 8'hFE, 8'h01, 32'd3);
      domain_req_i[0] = 1'b1;
      wait_bit(0, 0, 1'b1, "pu0_pwr_on");
      n = 1;
      for (int k = 0; k < 1100; k++) begin
         @(negedge clk_i);
         if (!pwr_en_o[0]) break;
         n++;
      end
      check("pu_wait_cycles", n, 1023);
      check("err_iso", 32'(iso_o[0]), 32'd1);
      check("err_flag", 32'(timeout_err_o[0]), 32'd1);
      push(8'h00, 8'h00, 8'h00, 8'h01, 8'hFE, 8'hFE, 8'h00, 32'd3);
      domain_req_i[0] = 1'b0; err_clear_i = 1'b1;
      @(negedge clk_i);
      err_clear_i = 1'b0;
      check("err_cleared", 32'(timeout_err_o), 32'd0);
      repeat (2) @(negedge clk_i);
      check("off_after_clear", 32'(pwr_en_o[0]), 32'd0);
      push(8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 32'd4);
      pwr_ack_i[0] = 1'b1; domain_req_i[0] = 1'b1;
      wait_cnt(32'd4);

      // Domain 1 request reasserted mid power-down
      push(8'h00, 8'h00, 8'h00, 8'h02, 8'hFD, 8'hFD, 8'h00, 32'd5);
      push(8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 32'd6);
      domain_req_i[1] = 1'b0; ret_req_i[1] = 1'b0;
      wait_bit(1, 1, 1'b1, "iso1");
      domain_req_i[1] = 1'b1;
      wait_bit(0, 1, 1'b0, "pd1_pwr_off");
      pwr_ack_i[1] = 1'b0;
      wait_cnt(32'd5);
      check("off1_cycle", 32'(pwr_en_o[1]), 32'd0);
      @(negedge clk_i);
      check("pu1_started", 32'(pwr_en_o[1]), 32'd1);
      pwr_ack_i[1] = 1'b1;
      wait_cnt(32'd6);

      // All domains together, then saturation near max
      push(8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 32'd14);
      push(8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 32'd22);
      domain_req_i = 8'h00; ret_req_i = 8'h00;
      wait_bit(0, 0, 1'b0, "all_pwr_off");
      pwr_ack_i = 8'h00;
      wait_cnt(32'd14);
      domain_req_i = 8'hFF;
      wait_bit(0, 0, 1'b1, "all_pwr_on");
      pwr_ack_i = 8'hFF;
      wait_cnt(32'd22);
      push(8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 32'hFFFF_FFFA);
      @(posedge clk_i);
      #2 force dut.count_q = 32'hFFFF_FFFA;
      #1 release dut.count_q;
      @(negedge clk_i);
      push(8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 32'hFFFF_FFFF);
      domain_req_i = 8'h00;
      wait_bit(0, 0, 1'b0, "sat_pwr_off");
      pwr_ack_i = 8'h00;
      wait_cnt(32'hFFFF_FFFF);
      domain_req_i = 8'hFF;
      wait_bit(0, 0, 1'b1, "sat_pwr_on");
      pwr_ack_i = 8'hFF;
      wait_bit(1, 0, 1'b0, "sat_iso_release");
      @(negedge clk_i);
      check("sat_hold", transition_count_o, 32'hFFFF_FFFF);
      check("sat_all_on", 32'(domain_on_o), 32'hFF);

      // Reset during PD_WAIT
      push(8'h08, 8'h00, 8'h00, 8'h08, 8'hFF, 8'hF7, 8'h00, 32'hFFFF_FFFF);
      push(8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 32'd0);
      domain_req_i[3] = 1'b0; ret_req_i[3] = 1'b1;
      wait_bit(0, 3, 1'b0, "pd3_pwr_off");
      @(posedge clk_i);
      #2 rst_ni = 1'b0;
      #1 check_reset("midreset");
      domain_req_i[3] = 1'b1; ret_req_i = 8'h00;
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (10) @(negedge clk_i);
      check("post_reset_on", 32'(domain_on_o), 32'hFF);
      check("post_reset_cnt", transition_count_o, 32'd0);
      check("events_left", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
